// File: rtl/divmod_recombine.sv
// divmod_recombine: sequential reconstructor/checker for a quotient/divisor/
// remainder triple. Rebuilds the dividend a = q*b + r with a shift-add
// multiplier (one partial product per cycle), flags r >= b, and reports the
// reduction-XOR parity of the rebuilt dividend.
//
// Optional feature macro: RECOMB_PARITY_CHECK_EN
//   defined   : p_in is captured at acceptance, parity_err = parity ^ p_in
//   undefined : p_in is unused, parity_err is constant 0
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready high only in IDLE)
//   q, b, r  [W-1:0]      quotient, divisor, remainder
//   p_in                  expected dividend parity (macro build only)
//   out_valid / out_ready output handshake
//   a_out   [2W-1:0]      rebuilt dividend
//   range_err             r >= b (includes b == 0), informational
//   parity                ^a_out
//   parity_err            parity mismatch against captured p_in
module divmod_recombine #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   q,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   r,
  input  logic           p_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] a_out,
  output logic           range_err,
  output logic           parity,
  output logic           parity_err
);

  localparam int unsigned AW = 2 * W;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_q;
  logic [W-1:0]    r_b;
  logic [AW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_range_pend;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [AW-1:0]   r_a_out;
  logic            r_range_err;
  logic            r_parity;

  logic [AW-1:0]   w_pp;
  logic [AW-1:0]   w_acc_nxt;
  logic            w_last;
  logic            w_accept;

  // Partial product for the current multiplier bit, kept in 2*W bits.
  assign w_pp      = r_q[r_cnt] ? ({{W{1'b0}}, r_b} << r_cnt) : '0;
  assign w_acc_nxt = r_acc + w_pp;
  assign w_last    = (r_cnt == CW'(W - 1));
  assign w_accept  = (r_state == S_IDLE) && in_valid && r_in_ready;

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_q          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_range_pend <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_a_out      <= '0;
      r_range_err  <= 1'b0;
      r_parity     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_q          <= q;
            r_b          <= b;
            r_acc        <= {{W{1'b0}}, r};
            r_cnt        <= '0;
            r_range_pend <= (r >= b);
            r_in_ready   <= 1'b0;
            r_state      <= S_MUL;
          end
        end
        S_MUL: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            // Result, flags and parity are published together.
            r_a_out     <= w_acc_nxt;
            r_range_err <= r_range_pend;
            r_parity    <= ^w_acc_nxt;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef RECOMB_PARITY_CHECK_EN
  logic r_p;
  logic r_parity_err;

  // Expected parity captured at acceptance, compared when the result lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p          <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_p <= p_in;
      end
      if ((r_state == S_MUL) && w_last) begin
        r_parity_err <= (^w_acc_nxt) ^ r_p;
      end
    end
  end

  assign parity_err = r_parity_err;
`else
  logic w_unused_p_in;
  assign w_unused_p_in = p_in;
  assign parity_err    = 1'b0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign a_out     = r_a_out;
  assign range_err = r_range_err;
  assign parity    = r_parity;

endmodule

// File: tb/tb_divmod_recombine.sv
module tb_divmod_recombine;

  localparam int unsigned W  = 4;
  localparam int unsigned AW = 2 * W;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   q;
  logic [W-1:0]   b;
  logic [W-1:0]   r;
  logic           p_in;
  logic           out_valid;
  logic           out_ready;
  logic [AW-1:0]  a_out;
  logic           range_err;
  logic           parity;
  logic           parity_err;

  int errors;
  int checks;

  divmod_recombine #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .q          (q),
    .b          (b),
    .r          (r),
    .p_in       (p_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a_out      (a_out),
    .range_err  (range_err),
    .parity     (parity),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: dividend from plain arithmetic, parity from popcount.
  function automatic logic [AW-1:0] ref_a(input int qq, input int bb, input int rr);
    int v;
    v = qq * bb + rr;
    return AW'(v);
  endfunction

  function automatic logic ref_parity(input int qq, input int bb, input int rr);
    int v;
    int ones;
    v = qq * bb + rr;
    ones = $countones(v);
    return logic'(ones % 2);
  endfunction

  function automatic logic ref_perr(input logic par, input logic pe);
`ifdef RECOMB_PARITY_CHECK_EN
    return par != pe;
`else
    return 1'b0;
`endif
  endfunction

  // One full transaction: wait for in_ready, present the triple, measure the
  // latency, check the result, hold it for 'stall' cycles, then transfer.
  task automatic do_txn(input int qq, input int bb, input int rr, input logic pe,
                        input int stall, input string tag);
    int lat;
    int waited;
    logic [AW-1:0] ea;
    logic er;
    logic ep;
    logic epe;
    ea  = ref_a(qq, bb, rr);
    er  = (rr >= bb);
    ep  = ref_parity(qq, bb, rr);
    epe = ref_perr(ep, pe);
    waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready_timeout got=%b want=1", tag, in_ready);
      return;
    end
    q = W'(qq); b = W'(bb); r = W'(rr); p_in = pe; in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    q = W'($urandom); b = W'($urandom); r = W'($urandom); p_in = 1'($urandom);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_accept in_ready=%b out_valid=%b want 0/0", tag, in_ready, out_valid);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== W) begin
      errors++;
      $display("FAIL %s latency got=%0d want=%0d", tag, lat, W);
    end
    checks++;
    if (a_out !== ea || range_err !== er || parity !== ep || parity_err !== epe) begin
      errors++;
      $display("FAIL %s result a=%0d re=%b p=%b pe=%b want a=%0d re=%b p=%b pe=%b",
               tag, a_out, range_err, parity, parity_err, ea, er, ep, epe);
    end
    for (int i = 0; i < stall; i++) begin
      // A new triple during DONE must be ignored.
      in_valid = 1'b1; q = W'($urandom); b = W'($urandom); r = W'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || a_out !== ea ||
          range_err !== er || parity !== ep || parity_err !== epe) begin
        errors++;
        $display("FAIL %s hold cyc=%0d ov=%b ir=%b a=%0d want ov=1 ir=0 a=%0d", tag, i,
                 out_valid, in_ready, a_out, ea);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s transfer ov=%b ir=%b want ov=0 ir=1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q = '0; b = '0; r = '0; p_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || a_out !== '0 || range_err !== 1'b0 ||
        parity !== 1'b0 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs ov=%b a=%0d re=%b p=%b pe=%b want all 0",
               out_valid, a_out, range_err, parity, parity_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_directed();
    do_txn(3, 5, 2, 1'b0, 0, "basic");
    do_txn(15, 15, 14, 1'b0, 0, "max");
    do_txn(0, 7, 6, 1'b0, 0, "q_zero");
    do_txn(9, 0, 3, 1'b0, 0, "b_zero");
    do_txn(2, 5, 5, 1'b0, 0, "r_eq_b");
  endtask

  task automatic test_back_to_back();
    do_txn(6, 3, 1, 1'b1, 0, "b2b_a");
    do_txn(1, 15, 0, 1'b0, 0, "b2b_b");
  endtask

  task automatic test_backpressure();
    do_txn(11, 13, 12, 1'b0, 5, "backpressure");
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_ghost ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    q = W'(13); b = W'(11); r = W'(7); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || a_out !== '0 || range_err !== 1'b0 ||
        parity !== 1'b0 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs ov=%b a=%0d re=%b p=%b want all 0",
               out_valid, a_out, range_err, parity);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    end
    do_txn(1, 1, 0, 1'b0, 0, "after_reset");
  endtask

  task automatic test_parity_check();
    do_txn(3, 5, 2, 1'b1, 0, "perr_p1");
    do_txn(3, 5, 2, 1'b0, 0, "perr_p0");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_txn(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)),
             1'($urandom), int'($urandom_range(3)), "random");
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_parity_check();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
